// File: rtl/spi_master_n.sv
// spi_master_n - parametrised SPI mode-0 bus master.
//
// A single-cycle start request (rw, cs_sel, addr, wdata) is serialised as
// {rw, addr, data} MSB-first on mosi/sclk with a per-device active-low
// chip select. Read data captured during the data field is returned on
// rdata together with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   start            request strobe, accepted only while ready=1
//   rw               1=read, 0=write (sampled with start)
//   cs_sel           target device index (sampled with start)
//   addr, wdata      address and write data (sampled with start)
//   ready            idle, able to accept start
//   done             one-cycle pulse at transaction end
//   err              one-cycle pulse when start carries cs_sel >= NUM_CS
//   rdata            last read data, valid from done
//   sclk, mosi, miso serial bus (sclk idles low)
//   cs_n             active-low selects, one-hot-low during a frame
//
// Build option: SPI_MISO_SYNC_EN adds a two-flop miso synchroniser and moves
// the sample point two clk cycles into the sclk high half (CLK_DIV >= 3).
module spi_master_n #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned NUM_CS  = 2,
  parameter int unsigned CLK_DIV = 4,
  localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W,
  localparam int unsigned SEL_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [SEL_W-1:0]  cs_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int unsigned CNT_W = $clog2(FRAME_W + 1);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic                sclk_q, sclk_d;
  logic [FRAME_W-1:0]  shreg_q, shreg_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                rw_q, rw_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                div_last;
  logic                sample_en;
  logic                miso_smp;
  logic                sel_ok;
  logic [NUM_CS-1:0]   sel_oh;

  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

`ifdef SPI_MISO_SYNC_EN
  if (CLK_DIV < 3) begin : g_div_chk
    $error("spi_master_n: CLK_DIV must be >= 3 when SPI_MISO_SYNC_EN is defined");
  end

  logic miso_s1_q, miso_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      miso_s1_q <= miso;
      miso_s2_q <= miso_s1_q;
    end
  end

  // The pin value present at the sclk rise reaches miso_s2_q one cycle later;
  // take it on the edge ending the second high-half cycle.
  assign miso_smp  = miso_s2_q;
  assign sample_en = (state_q == SHIFT) && sclk_q && (div_q == DIV_W'(1));
`else
  assign miso_smp  = miso;
  assign sample_en = (state_q == SHIFT) && !sclk_q && div_last;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    shreg_d = shreg_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    cs_n_d  = cs_n_q;
    rw_d    = rw_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    sel_ok  = 1'b0;
    sel_oh  = '0;

    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (cs_sel == SEL_W'(i)) begin
        sel_ok    = 1'b1;
        sel_oh[i] = 1'b1;
      end
    end

    // Shift every sample in; the last DATA_W samples are the data field.
    if (sample_en) rx_d = DATA_W'({rx_q, miso_smp});

    case (state_q)
      IDLE: begin
        if (start) begin
          if (sel_ok) begin
            state_d = SETUP;
            div_d   = '0;
            rw_d    = rw;
            // Data field is zeroed for reads so mosi idles low there.
            shreg_d = {rw, addr, rw ? {DATA_W{1'b0}} : wdata};
            cs_n_d  = ~sel_oh;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        div_d = div_last ? '0 : div_q + 1'b1;
        if (div_last) begin
          state_d = SHIFT;
          bit_d   = '0;
        end
      end
      SHIFT: begin
        div_d = div_last ? '0 : div_q + 1'b1;
        if (div_last) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: advance mosi. After the last bit the register
            // has shifted empty, so mosi rests at 0.
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
            if (bit_q == CNT_W'(FRAME_W - 1)) begin
              state_d = HOLD;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
      HOLD: begin
        div_d = div_last ? '0 : div_q + 1'b1;
        if (div_last) begin
          state_d = IDLE;
          cs_n_d  = '1;
          done_d  = 1'b1;
          if (rw_q) rdata_d = rx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      shreg_q <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      cs_n_q  <= '1;
      rw_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      shreg_q <= shreg_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      cs_n_q  <= cs_n_d;
      rw_q    <= rw_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign sclk  = sclk_q;
  assign mosi  = shreg_q[FRAME_W-1];
  assign cs_n  = cs_n_q;

endmodule

// File: tb/tb_spi_master_n.sv
// tb_spi_master_n - directed self-checking bench for spi_master_n.
// Uses NUM_CS=3 so that cs_sel has an out-of-range code for the err path.
// CLK_DIV is 2 by default and 3 when SPI_MISO_SYNC_EN is defined.
module tb_spi_master_n;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned NUM_CS = 3;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned FRM    = 16;
`ifdef SPI_MISO_SYNC_EN
  localparam int unsigned CLK_DIV = 3;
`else
  localparam int unsigned CLK_DIV = 2;
`endif
  // Sample index 1 is the cycle right after the accepting edge.
  localparam int unsigned RISE_AT = 2 * CLK_DIV + 1;
  localparam int unsigned DONE_AT = 2 * CLK_DIV + 2 * CLK_DIV * FRM + 1;
  localparam int unsigned LIMIT   = 400;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              rw;
  logic [SEL_W-1:0]  cs_sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [NUM_CS-1:0] cs_n;

  int unsigned total = 0;
  int unsigned bad   = 0;

  spi_master_n #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_CS (NUM_CS),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .rw    (rw),
    .cs_sel(cs_sel),
    .addr  (addr),
    .wdata (wdata),
    .ready (ready),
    .done  (done),
    .err   (err),
    .rdata (rdata),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso),
    .cs_n  (cs_n)
  );

  always #5 clk = ~clk;

  // Bus monitor: count sclk rises and collect mosi at each rise.
  int unsigned nrise = 0;
  logic [15:0] mosi_cap = '0;
  int unsigned ndone = 0;

  always @(posedge sclk) begin
    nrise = nrise + 1;
    mosi_cap = {mosi_cap[14:0], mosi};
  end

  always @(posedge clk) if (done === 1'b1) ndone = ndone + 1;

  // Mode-0 slave: first bit presented when a select falls, next bit on each
  // falling sclk.
  logic [15:0] sl_pat = '0;
  int          sl_idx = 0;

  always @(cs_n) begin
    if (cs_n != '1) begin
      sl_idx = 0;
      miso = sl_pat[15];
    end
  end

  always @(negedge sclk) begin
    sl_idx = sl_idx + 1;
    miso = (sl_idx < 16) ? sl_pat[15 - sl_idx] : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction, leaving the bench in the done cycle so a caller can
  // issue the next start back-to-back.
  task automatic run(input logic r, input logic [SEL_W-1:0] sel,
                     input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                     input logic [15:0] pat, input logic [NUM_CS-1:0] exp_cs,
                     input logic [15:0] exp_mosi, input bit poke);
    int unsigned k;
    int unsigned done_at;
    int unsigned first_hi;
    sl_pat   = pat;
    nrise    = 0;
    mosi_cap = '0;
    rw       = r;
    cs_sel   = sel;
    addr     = a;
    wdata    = wd;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    done_at  = 0;
    first_hi = 0;
    for (k = 1; k <= LIMIT; k++) begin
      if (k == 1) begin
        chk("cs_n_active", 32'(cs_n), 32'(exp_cs));
        chk("busy_ready", 32'(ready), 32'd0);
        chk("mosi_first", 32'(mosi), 32'(r));
      end
      if (sclk && first_hi == 0) first_hi = k;
      if (poke && k == 10) begin
        rw     = ~r;
        cs_sel = 2'd3;
        start  = 1'b1;
      end
      if (poke && k == 11) begin
        start = 1'b0;
        chk("busy_no_err", 32'(err), 32'd0);
      end
      if (done) begin
        done_at = k;
        break;
      end
      tick();
    end
    chk("done_time", done_at, DONE_AT);
    chk("first_rise", first_hi, RISE_AT);
    chk("sclk_pulses", nrise, 32'd16);
    chk("mosi_frame", 32'(mosi_cap), 32'(exp_mosi));
    chk("cs_n_release", 32'(cs_n), 32'(3'b111));
    chk("done_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    int unsigned dcount;
    rst_n  = 1'b0;
    start  = 1'b0;
    rw     = 1'b0;
    cs_sel = '0;
    addr   = '0;
    wdata  = '0;
    miso   = 1'b0;

    tick(); tick(); tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_cs_n", 32'(cs_n), 32'(3'b111));
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(ready), 32'd1);
    chk("idle_cs_n", 32'(cs_n), 32'(3'b111));
    chk("idle_sclk", 32'(sclk), 32'd0);
    chk("idle_mosi", 32'(mosi), 32'd0);
    chk("idle_rdata", 32'(rdata), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_err", 32'(err), 32'd0);

    // Write: {0, 2A, C3} = 16'h2AC3; rdata must stay 0.
    run(1'b0, 2'd1, 7'h2A, 8'hC3, 16'hFFFF, 3'b101, 16'h2AC3, 1'b0);
    chk("wr_rdata", 32'(rdata), 32'd0);
    tick();
    chk("done_pulse", 32'(done), 32'd0);

    // Read with an ignored start mid-frame: {1, 05, 00} = 16'h8500.
    run(1'b1, 2'd0, 7'h05, 8'hFF, 16'hA55A, 3'b110, 16'h8500, 1'b1);
    chk("rd_rdata", 32'(rdata), 32'h5A);
    // Back-to-back write issued in the done cycle: {0, 7F, 81} = 16'h7F81.
    run(1'b0, 2'd2, 7'h7F, 8'h81, 16'h0000, 3'b011, 16'h7F81, 1'b0);
    chk("b2b_rdata", 32'(rdata), 32'h5A);
    tick();

    // Select error.
    nrise  = 0;
    cs_sel = 2'd3;
    rw     = 1'b1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_ready", 32'(ready), 32'd1);
    chk("err_cs_n", 32'(cs_n), 32'(3'b111));
    tick();
    chk("err_width", 32'(err), 32'd0);
    for (int i = 0; i < 20; i++) tick();
    chk("err_no_sclk", nrise, 32'd0);
    chk("err_no_start", 32'(ready), 32'd1);

    // Abort a read after bit 5.
    sl_pat = 16'hA55A;
    nrise  = 0;
    rw     = 1'b1;
    cs_sel = 2'd1;
    addr   = 7'h11;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (nrise == 5 && sclk == 1'b0) break;
      tick();
    end
    chk("abort_reach", nrise, 32'd5);
    dcount = ndone;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 32'(cs_n), 32'(3'b111));
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("abort_no_done", ndone, dcount);
    chk("abort_rdata", 32'(rdata), 32'd0);

    // Recovery read.
    run(1'b1, 2'd1, 7'h05, 8'h00, 16'hA55A, 3'b101, 16'h8500, 1'b0);
    chk("rec_rdata", 32'(rdata), 32'h5A);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
